text_console: RTL and testbench

Parametrised character-terminal engine that sits between the UART receiver and the font/video path. It accepts a byte stream with a valid/ready handshake, interprets printable characters and a small set of control codes, and maintains a COLS×ROWS character buffer with hardware scrolling through a circular top-row pointer. It exposes a synchronous read port for the video scan-out and returns a blinking-cursor flag for the addressed cell, so the cursor is no longer written into character memory.

---
 rtl/text_console_pkg.sv | 25 ++
 rtl/console_ram.sv | 40 ++++
 rtl/text_console.sv | 199 +++++++++++++++++++
 tb/tb_text_console.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_console_pkg.sv
`default_nettype none
// =============================================================================
// text_console_pkg : control codes, printable range and engine states
// Revision: 1.0
// =============================================================================
package text_console_pkg;

  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_TAB = 8'h09;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_FF  = 8'h0C;
  localparam logic [7:0] CHAR_CR  = 8'h0D;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    CLR_ROW = 2'd2,
    CLR_ALL = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/console_ram.sv
`default_nettype none
// =============================================================================
// console_ram : character store, one write port, registered read-first read
// Revision: 1.0
// =============================================================================
module console_ram #(
  parameter int DEPTH = 2400,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Only the output register is reset; the array itself stays resetless.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/text_console.sv
`default_nettype none
// =============================================================================
// text_console : byte-stream character terminal with circular-row scrolling
// Revision: 1.0
// =============================================================================
module text_console #(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 30,
  parameter int         TAB_W     = 8,
  parameter int         BLINK_DIV = 2**23,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [$clog2(COLS)-1:0]   rd_col,
  input  logic [$clog2(ROWS)-1:0]   rd_row,
  output logic [7:0]                rd_char,
  output logic                      rd_cursor,
  output logic [$clog2(COLS)-1:0]   cur_x,
  output logic [$clog2(ROWS)-1:0]   cur_y
);

  import text_console_pkg::*;

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t          state_q;
  logic [CW-1:0]   cur_x_q;
  logic [RW-1:0]   cur_y_q;
  logic [RW-1:0]   top_q;
  logic [AW-1:0]   clr_cnt_q;
  logic [BW-1:0]   blink_cnt_q;
  logic            blink_on_q;
  logic            rd_cursor_q;

  logic            w_accept;
  logic            w_printable;
  logic            w_newline;
  logic [31:0]     w_tab_sum;
  logic [CW-1:0]   w_tab_x;
  logic [AW-1:0]   w_cur_addr;
  logic [AW-1:0]   w_clr_row_base;
  logic [AW-1:0]   w_raddr;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [7:0]      w_wdata;

  // Logical-to-physical row: one add and one conditional subtract.
  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] lrow,
                                             input logic [RW-1:0] top);
    logic [RW:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= (RW+1)'(ROWS)) begin
      sum = sum - (RW+1)'(ROWS);
    end
    return RW'(sum);
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow,
                                              input logic [CW-1:0] col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  assign in_ready    = (state_q == IDLE);
  assign w_accept    = in_valid && in_ready;
  assign w_printable = (in_data >= PRINT_LO) && (in_data <= PRINT_HI);
  assign w_newline   = w_accept &&
                       ((w_printable && (cur_x_q == CW'(COLS-1))) || (in_data == CHAR_LF));

  assign w_tab_sum = (32'(cur_x_q) | 32'(TAB_W-1)) + 32'd1;
  assign w_tab_x   = (w_tab_sum > 32'(COLS-1)) ? CW'(COLS-1) : CW'(w_tab_sum);

  assign w_cur_addr     = cell_addr(phys_row(cur_y_q, top_q), cur_x_q);
  assign w_clr_row_base = cell_addr(phys_row(RW'(ROWS-1), top_q), '0);
  assign w_raddr        = cell_addr(phys_row(rd_row, top_q), rd_col);

  always_comb begin
    w_we    = 1'b0;
    w_waddr = clr_cnt_q;
    w_wdata = FILL_CHAR;
    case (state_q)
      INIT, CLR_ALL: w_we = 1'b1;
      CLR_ROW: begin
        w_we    = 1'b1;
        w_waddr = w_clr_row_base + clr_cnt_q;
      end
      IDLE: begin
        if (w_accept && w_printable) begin
          w_we    = 1'b1;
          w_waddr = w_cur_addr;
          w_wdata = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      top_q     <= '0;
    end else begin
      case (state_q)
        INIT, CLR_ALL: begin
          if (clr_cnt_q == AW'(CELLS-1)) begin
            clr_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            clr_cnt_q <= clr_cnt_q + AW'(1);
          end
        end
        CLR_ROW: begin
          if (clr_cnt_q == AW'(COLS-1)) begin
            clr_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            clr_cnt_q <= clr_cnt_q + AW'(1);
          end
        end
        IDLE: begin
          clr_cnt_q <= '0;
          if (w_accept) begin
            if (w_printable) begin
              cur_x_q <= (cur_x_q == CW'(COLS-1)) ? '0 : cur_x_q + CW'(1);
            end else begin
              case (in_data)
                CHAR_CR:  cur_x_q <= '0;
                CHAR_BS:  if (cur_x_q != '0) cur_x_q <= cur_x_q - CW'(1);
                CHAR_TAB: cur_x_q <= w_tab_x;
                CHAR_FF: begin
                  cur_x_q <= '0;
                  cur_y_q <= '0;
                  top_q   <= '0;
                  state_q <= CLR_ALL;
                end
                default: ;
              endcase
            end
            // At the bottom row a newline scrolls: advance top, then blank the new bottom.
            if (w_newline) begin
              if (cur_y_q != RW'(ROWS-1)) begin
                cur_y_q <= cur_y_q + RW'(1);
              end else begin
                top_q   <= (top_q == RW'(ROWS-1)) ? '0 : top_q + RW'(1);
                state_q <= CLR_ROW;
              end
            end
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      rd_cursor_q <= 1'b0;
    end else begin
      if (blink_cnt_q == BW'(BLINK_DIV-1)) begin
        blink_cnt_q <= '0;
        blink_on_q  <= ~blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
      rd_cursor_q <= blink_on_q && (rd_row == cur_y_q) && (rd_col == cur_x_q);
    end
  end

  console_ram #(
    .DEPTH (CELLS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (w_we),
    .waddr_i (w_waddr),
    .wdata_i (w_wdata),
    .raddr_i (w_raddr),
    .rdata_o (rd_char)
  );

  assign rd_cursor = rd_cursor_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;

endmodule
`default_nettype wire

// File: tb/tb_text_console.sv
`default_nettype none
// =============================================================================
// tb_text_console : directed self-checking bench for text_console
// Revision: 1.0
// =============================================================================
module tb_text_console;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] rd_col;
  logic [4:0] rd_row;
  logic [7:0] rd_char;
  logic       rd_cursor;
  logic [6:0] cur_x;
  logic [4:0] cur_y;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  text_console #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .TAB_W     (8),
    .BLINK_DIV (4),
    .FILL_CHAR (8'h20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rd_col    (rd_col),
    .rd_row    (rd_row),
    .rd_char   (rd_char),
    .rd_cursor (rd_cursor),
    .cur_x     (cur_x),
    .cur_y     (cur_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycles since reset release, used to predict the blink phase.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!in_ready && n < 6000);
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic rd(input int row, input int col);
    @(negedge clk);
    rd_row = 5'(row);
    rd_col = 7'(col);
    @(posedge clk); #1;
  endtask

  task automatic check_row(input int row, input int c0, input logic [7:0] v, input string tag);
    int bad = 0;
    for (int c = c0; c < COLS; c++) begin
      rd(row, c);
      if (rd_char !== v) bad++;
    end
    chk($sformatf("%s_r%0d", tag, row), bad, 0);
  endtask

  initial begin
    int n;
    in_data  = 8'h00;
    in_valid = 1'b0;
    rd_row   = '0;
    rd_col   = '0;
    reset    = 1'b1;

    // Reset state and INIT duration
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_curx", 32'(cur_x), 0);
    chk("rst_cury", 32'(cur_y), 0);
    chk("rst_rdchar", 32'(rd_char), 0);
    chk("rst_rdcursor", 32'(rd_cursor), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n);
    chk("init_len", n, ROWS*COLS);

    // "AB"
    send(8'h41);
    send(8'h42);
    chk("ab_curx", 32'(cur_x), 2);
    chk("ab_cury", 32'(cur_y), 0);
    rd(0, 0); chk("ab_c00", 32'(rd_char), 32'h41);
    rd(0, 1); chk("ab_c01", 32'(rd_char), 32'h42);
    check_row(0, 2, 8'h20, "ab_blank");
    check_row(1, 0, 8'h20, "ab_blank");
    rd(29, 79); chk("ab_c2979", 32'(rd_char), 32'h20);

    // A full row of 'x' wraps the cursor without scrolling
    send(8'h0D);
    repeat (80) send(8'h78);
    chk("wrap_curx", 32'(cur_x), 0);
    chk("wrap_cury", 32'(cur_y), 1);
    chk("wrap_ready", 32'(in_ready), 1);
    check_row(0, 0, 8'h78, "row_x");
    check_row(1, 0, 8'h20, "wrap_blank");

    // Fill rows 1..29 with 0x40+row, leaving the last cell free
    for (int r = 1; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!(r == ROWS-1 && c == COLS-1)) send(8'(8'h40 + r));
    chk("fill_curx", 32'(cur_x), 79);
    chk("fill_cury", 32'(cur_y), 29);
    rd(1, 0);   chk("fill_c0100", 32'(rd_char), 32'h41);
    rd(15, 40); chk("fill_c1540", 32'(rd_char), 32'h4F);
    rd(29, 78); chk("fill_c2978", 32'(rd_char), 32'h5D);
    rd(0, 79);  chk("fill_c0079", 32'(rd_char), 32'h78);

    // Form feed clears everything
    send(8'h0C);
    chk("ff_drop", 32'(in_ready), 0);
    wait_ready(n);
    chk("ff_len", n, ROWS*COLS);
    chk("ff_curx", 32'(cur_x), 0);
    chk("ff_cury", 32'(cur_y), 0);
    for (int r = 0; r < ROWS; r++) check_row(r, 0, 8'h20, "ff_blank");

    // 30 line feeds; the last one scrolls
    send(8'h4D);
    send(8'h0D);
    send(8'h0A);
    send(8'h52);
    send(8'h0D);
    repeat (28) send(8'h0A);
    chk("lf29_cury", 32'(cur_y), 29);
    chk("lf29_ready", 32'(in_ready), 1);
    send(8'h0A);
    chk("scroll_drop", 32'(in_ready), 0);
    wait_ready(n);
    chk("scroll_len", n, COLS);
    chk("scroll_cury", 32'(cur_y), 29);
    chk("scroll_curx", 32'(cur_x), 0);
    rd(0, 0); chk("scroll_c0000", 32'(rd_char), 32'h52);
    check_row(0, 1, 8'h20, "scroll_r0");
    check_row(29, 0, 8'h20, "scroll_bottom");
    rd(28, 0); chk("scroll_c2800", 32'(rd_char), 32'h20);

    // Backspace and tab
    send(8'h41); send(8'h42); send(8'h43);
    send(8'h08); send(8'h08);
    send(8'h5A);
    chk("bs_curx", 32'(cur_x), 2);
    rd(29, 0); chk("bs_c0", 32'(rd_char), 32'h41);
    rd(29, 1); chk("bs_c1", 32'(rd_char), 32'h5A);
    rd(29, 2); chk("bs_c2", 32'(rd_char), 32'h43);
    send(8'h0D);
    send(8'h08);
    chk("bs_at0", 32'(cur_x), 0);
    send(8'h41); send(8'h42); send(8'h43);
    send(8'h09);
    chk("tab_3", 32'(cur_x), 8);
    send(8'h0D);
    repeat (9) send(8'h09);
    chk("tab_72", 32'(cur_x), 72);
    repeat (6) send(8'h79);
    send(8'h09);
    chk("tab_78", 32'(cur_x), 79);
    send(8'h09);
    chk("tab_79", 32'(cur_x), 79);
    chk("tab_cury", 32'(cur_y), 29);
    send(8'h01);
    chk("discard_curx", 32'(cur_x), 79);
    chk("discard_ready", 32'(in_ready), 1);

    // Reset in the middle of a form-feed clear
    send(8'h0C);
    chk("ff2_drop", 32'(in_ready), 0);
    repeat (99) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_ready", 32'(in_ready), 0);
    chk("midrst_curx", 32'(cur_x), 0);
    chk("midrst_rdchar", 32'(rd_char), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n);
    chk("reinit_len", n, ROWS*COLS);
    chk("reinit_curx", 32'(cur_x), 0);
    chk("reinit_cury", 32'(cur_y), 0);
    for (int r = 0; r < ROWS; r++) check_row(r, 0, 8'h20, "reinit_blank");

    // Cursor blink at (row 2, col 5)
    send(8'h0A);
    send(8'h0A);
    repeat (5) send(8'h62);
    chk("blink_curx", 32'(cur_x), 5);
    chk("blink_cury", 32'(cur_y), 2);
    @(negedge clk);
    rd_row = 5'd2;
    rd_col = 7'd5;
    repeat (16) begin
      @(posedge clk); #1;
      chk($sformatf("blink_on_c%0d", cyc), 32'(rd_cursor),
          32'((((cyc - 1) >> 2) & 1) == 0));
      chk("blink_char", 32'(rd_char), 32'h20);
    end
    @(negedge clk);
    rd_col = 7'd4;
    repeat (8) begin
      @(posedge clk); #1;
      chk("blink_other", 32'(rd_cursor), 0);
    end
    rd(2, 4); chk("blink_c0204", 32'(rd_char), 32'h62);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
